// File: rtl/cbus_arbiter.sv
// Round-robin arbiter that shares one cache bus between NUM_MASTERS cache controllers.
// Optional per-master grant/wait statistics are compiled in with `define CBUS_ARB_STAT_EN.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t oresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t iresp
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W:0]   cand;
  logic             any_valid;
  logic             burst_done;

  // First valid master scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
      if (!any_valid && ireqs[cand[IDX_W-1:0]].valid) begin
        any_valid = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  assign burst_done = iresp.ready && iresp.last;
  assign next_ptr   = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant_idx <= winner;
          state     <= BUSY;
        end
        BUSY: if (burst_done) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end
      endcase
    end
  end

  // Outputs are gated by state, so an async reset zeroes them in the same cycle.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      oresps[i] = '0;
      if (state == BUSY && grant_idx == IDX_W'(i)) oresps[i] = iresp;
    end
    if (state == BUSY) oreq = ireqs[grant_idx];
  end

`ifdef CBUS_ARB_STAT_EN
  logic [31:0] grant_cnt [NUM_MASTERS];
  logic [31:0] wait_cnt  [NUM_MASTERS];

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these counter arrays are a handful of flops, not a RAM, so they take a real reset.
    if (reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_cnt[i] <= '0;
        wait_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (state == IDLE && any_valid && winner == IDX_W'(i))
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (ireqs[i].valid && !(state == BUSY && grant_idx == IDX_W'(i)))
          wait_cnt[i] <= wait_cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter (3 masters): directed scenarios plus random traffic
// compared every cycle against a queue/arithmetic model of the round-robin rules.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t oresps [N];
  cbus_req_t  oreq;
  cbus_resp_t iresp;

  int total = 0;
  int bad   = 0;

  // Reference model: owner = -1 when nobody holds the bus.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_grants [$];

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .oresps (oresps),
    .oreq   (oreq),
    .iresp  (iresp)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cbus_req_t mk(input logic wr, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [31:0] data);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = wr ? 4'hF : 4'h0;
    r.data     = data;
    r.len      = len;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last, input logic [31:0] data);
    iresp.ready = 1'b1;
    iresp.last  = last;
    iresp.data  = data;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    iresp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && ireqs[(m_ptr + k) % N].valid) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_grants.push_back(w);
      end
    end else if (iresp.ready && iresp.last) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  end

  always @(negedge clk) begin
    cbus_req_t  eq;
    cbus_resp_t er;
    eq = '0;
    if (!reset && m_owner >= 0) eq = ireqs[m_owner];
    check("oreq", oreq, eq);
    for (int i = 0; i < N; i++) begin
      er = '0;
      if (!reset && m_owner == i) er = iresp;
      check($sformatf("oresps[%0d]", i), oresps[i], er);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] wd [4];
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;

    reset = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    check("rst_oreq_valid", oreq.valid, 0);
    check("rst_oresps0", oresps[0], 0);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    tick();
    reset = 1'b0;

    // Lone ICache read, 4 beats
    ireqs[0] = mk(1'b0, 32'h8000_0000, 8'd3, 32'h0);
    @(negedge clk);
    check("t1_latency_idle", oreq.valid, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      beat(b == 3, 32'hD0 + b);
      @(negedge clk);
      check("t1_oreq_valid", oreq.valid, 1);
      check("t1_addr", oreq.addr, 32'h8000_0000);
      check("t1_ready0", oresps[0].ready, 1);
      check("t1_last0", oresps[0].last, b == 3);
      check("t1_data0", oresps[0].data, 32'hD0 + b);
      check("t1_ready1", oresps[1].ready, 0);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("t1_state_idle", dut.state, 0);
    check("t1_rr_ptr", dut.rr_ptr, 1);
    check("t1_model_ptr", m_ptr, 1);
    check("t1_oreq_off", oreq.valid, 0);
    tick();

    // Simultaneous ICache + DCache after reset
    do_reset();
    ireqs[0] = mk(1'b0, 32'h1000_0000, 8'd1, 32'h0);
    ireqs[1] = mk(1'b0, 32'h2000_0000, 8'd0, 32'h0);
    tick();
    for (int b = 0; b < 2; b++) begin
      beat(b == 1, 32'hA0 + b);
      @(negedge clk);
      check("t2_m0_addr", oreq.addr, 32'h1000_0000);
      check("t2_m0_ready", oresps[0].ready, 1);
      check("t2_m1_blocked", oresps[1].ready, 0);
      tick();
    end
    ireqs[0] = '0;
    iresp    = '0;
    @(negedge clk);
    check("t2_bubble", oreq.valid, 0);
    tick();
    beat(1'b1, 32'hB0);
    @(negedge clk);
    check("t2_m1_addr", oreq.addr, 32'h2000_0000);
    check("t2_m1_data", oresps[1].data, 32'hB0);
    tick();
    idle_inputs();

    // Fairness: two always-valid masters, 8 single-beat transactions
    do_reset();
    m_grants.delete();
    ireqs[0] = mk(1'b0, 32'h3000_0000, 8'd0, 32'h0);
    ireqs[1] = mk(1'b0, 32'h3100_0000, 8'd0, 32'h0);
    tick();
    for (int t = 0; t < 8; t++) begin
      beat(1'b1, 32'h0);
      @(negedge clk);
      check($sformatf("t3_grant%0d", t), oreq.addr, (t % 2 == 0) ? 32'h3000_0000 : 32'h3100_0000);
      tick();
      iresp = '0;
      if (t == 7) idle_inputs();
      @(negedge clk);
      check("t3_bubble", oreq.valid, 0);
      tick();
    end
    check("t3_model_count", m_grants.size(), 8);
    for (int t = 0; t < m_grants.size(); t++)
      check($sformatf("t3_model_order%0d", t), m_grants[t], t % 2);
`ifdef CBUS_ARB_STAT_EN
    check("t3_grant_cnt0", dut.grant_cnt[0], 4);
    check("t3_grant_cnt1", dut.grant_cnt[1], 4);
`endif

    // DCache write burst with ICache request raised on beat 2
    ireqs[1] = mk(1'b1, 32'h4000_0000, 8'd3, wd[0]);
    tick();
    for (int b = 0; b < 4; b++) begin
      ireqs[1].data = wd[b];
      if (b == 1) ireqs[0] = mk(1'b0, 32'h4800_0000, 8'd0, 32'h0);
      beat(b == 3, 32'h0);
      @(negedge clk);
      check("t4_wdata", oreq.data, wd[b]);
      check("t4_strobe", oreq.strobe, 4'hF);
      check("t4_is_write", oreq.is_write, 1);
      check("t4_m0_waits", oresps[0].ready, 0);
      tick();
    end
    ireqs[1] = '0;
    iresp    = '0;
    @(negedge clk);
    check("t4_bubble", oreq.valid, 0);
    tick();
    beat(1'b1, 32'hC0);
    @(negedge clk);
    check("t4_m0_addr", oreq.addr, 32'h4800_0000);
    tick();
    idle_inputs();

    // Reset on beat 2 of a 4-beat burst, master 1 pending
    ireqs[0] = mk(1'b0, 32'h5000_0000, 8'd3, 32'h0);
    tick();
    beat(1'b0, 32'hE0);
    ireqs[1] = mk(1'b0, 32'h5100_0000, 8'd0, 32'h0);
    @(negedge clk);
    check("t5_m0_addr", oreq.addr, 32'h5000_0000);
    tick();
    beat(1'b0, 32'hE1);
    #1 reset = 1'b1;
    #1;
    check("t5_async_oreq", oreq.valid, 0);
    check("t5_async_resp0", oresps[0], 0);
    check("t5_async_resp1", oresps[1], 0);
    tick();
    reset    = 1'b0;
    ireqs[0] = '0;
    iresp    = '0;
    @(negedge clk);
    check("t5_rr_ptr", dut.rr_ptr, 0);
    tick();
    beat(1'b1, 32'hF0);
    @(negedge clk);
    check("t5_m1_addr", oreq.addr, 32'h5100_0000);
    tick();
    idle_inputs();

    // Wrap-around: masters 0 and 2 valid with rr_ptr=1
    do_reset();
    ireqs[0] = mk(1'b0, 32'h6000_0000, 8'd0, 32'h0);
    tick();
    beat(1'b1, 32'h0);
    @(negedge clk);
    tick();
    iresp    = '0;
    ireqs[2] = mk(1'b0, 32'h6200_0000, 8'd0, 32'h0);
    @(negedge clk);
    check("t6_rr_ptr", dut.rr_ptr, 1);
    tick();
    beat(1'b1, 32'h0);
    @(negedge clk);
    check("t6_first_m2", oreq.addr, 32'h6200_0000);
    tick();
    ireqs[2] = '0;
    iresp    = '0;
    tick();
    beat(1'b1, 32'h0);
    @(negedge clk);
    check("t6_then_m0", oreq.addr, 32'h6000_0000);
    tick();
    idle_inputs();

    // Random traffic, checked every cycle by the compare process
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        ireqs[i].valid    = 1'($urandom_range(0, 1));
        ireqs[i].is_write = 1'($urandom);
        ireqs[i].size     = 3'($urandom);
        ireqs[i].addr     = $urandom;
        ireqs[i].strobe   = 4'($urandom);
        ireqs[i].data     = $urandom;
        ireqs[i].len      = 8'($urandom);
      end
      iresp.ready = 1'($urandom_range(0, 1));
      iresp.last  = ($urandom_range(0, 2) == 0);
      iresp.data  = $urandom;
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
